// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - integer clock divider, registered glitch-free output in the I_CLK domain
module clk_divider #(
    parameter int unsigned N = 2
) (
    input  logic I_CLK,
    input  logic Rst,
    output logic O_CLK
);

    localparam int unsigned     CW      = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(N - 1);
    // Low phase is T = N - floor(N/2) cycles, so odd ratios stretch the low phase.
    localparam logic [CW-1:0]   T_VAL   = CW'(N - N / 2);

    generate
        if (N < 2) begin : g_bad_ratio
            $error("clk_divider: N must be at least 2");
        end
    endgenerate

    // Power-up values let the divider run correctly with Rst tied low.
    logic [CW-1:0] cnt_q = '0;
    logic [CW-1:0] cnt_d;
    logic          o_clk_q = 1'b0;
    logic          o_clk_d;

    always_comb begin
        cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        o_clk_d = (cnt_d >= T_VAL);
    end

    always_ff @(posedge I_CLK) begin
        if (Rst) begin
            cnt_q   <= '0;
            o_clk_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            o_clk_q <= o_clk_d;
        end
    end

    assign O_CLK = o_clk_q;

endmodule

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - self-checking bench for clk_divider at N = 2, 4, 5, 100 and with no reset
module tb_clk_divider;

    logic clk;
    logic r2, r4, r5, r100;
    logic o2, o4, o5, o100, o2nr;
    logic rst_tied;

    int checks = 0;
    int errors = 0;

    clk_divider #(.N(2))   u2   (.I_CLK(clk), .Rst(r2),       .O_CLK(o2));
    clk_divider #(.N(4))   u4   (.I_CLK(clk), .Rst(r4),       .O_CLK(o4));
    clk_divider #(.N(5))   u5   (.I_CLK(clk), .Rst(r5),       .O_CLK(o5));
    clk_divider #(.N(100)) u100 (.I_CLK(clk), .Rst(r100),     .O_CLK(o100));
    clk_divider #(.N(2))   u2nr (.I_CLK(clk), .Rst(rst_tied), .O_CLK(o2nr));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit rst;
        bit o2;
        bit o4;
        bit o5;
        int c4;
        int c5;
        bit onr;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl[NVEC];
    vec_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        bit   p4[4];
        bit   p5[5];
        vec_t e;
        bit   prev;
        int   last_edge;
        int   rises;
        int   falls;

        p4 = '{1'b0, 1'b1, 1'b1, 1'b0};
        p5 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        // Three reset cycles, then 15 free-running edges.
        for (int i = 0; i < 3; i++) begin
            tbl[i] = '{rst: 1'b1, o2: 1'b0, o4: 1'b0, o5: 1'b0, c4: 0, c5: 0,
                       onr: bit'((i + 1) % 2)};
        end
        for (int k = 1; k <= 15; k++) begin
            tbl[2 + k] = '{rst: 1'b0, o2: bit'(k % 2), o4: p4[(k - 1) % 4],
                           o5: p5[(k - 1) % 5], c4: k % 4, c5: k % 5,
                           onr: bit'((k + 3) % 2)};
        end

        rst_tied = 1'b0;
        r2 = 1'b1; r4 = 1'b1; r5 = 1'b1; r100 = 1'b1;
        #1;
        check("norst_initial_oclk", int'(o2nr), 0);
        check("norst_initial_cnt", int'(u2nr.cnt_q), 0);

        for (int i = 0; i < NVEC; i++) begin
            r2 = tbl[i].rst; r4 = tbl[i].rst; r5 = tbl[i].rst;
            sb.push_back(tbl[i]);
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("n2_oclk[%0d]", i), int'(o2), int'(e.o2));
            check($sformatf("n4_oclk[%0d]", i), int'(o4), int'(e.o4));
            check($sformatf("n4_cnt[%0d]", i), int'(u4.cnt_q), e.c4);
            check($sformatf("n5_oclk[%0d]", i), int'(o5), int'(e.o5));
            check($sformatf("n5_cnt[%0d]", i), int'(u5.cnt_q), e.c5);
            check($sformatf("norst_oclk[%0d]", i), int'(o2nr), int'(e.onr));
        end

        // N=4: reset arriving mid high phase truncates it on that very edge.
        r4 = 1'b1;
        @(posedge clk); @(negedge clk);
        r4 = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("midrst_before_oclk", int'(o4), 1);
        r4 = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midrst_oclk", int'(o4), 0);
        check("midrst_cnt", int'(u4.cnt_q), 0);
        r4 = 1'b0;
        @(posedge clk); @(negedge clk);
        check("midrst_rel1_oclk", int'(o4), 0);
        check("midrst_rel1_cnt", int'(u4.cnt_q), 1);
        @(posedge clk); @(negedge clk);
        check("midrst_rel2_oclk", int'(o4), 1);
        check("midrst_rel2_cnt", int'(u4.cnt_q), 2);

        // N=100: 1000 edges after release give 10 periods of 50 high / 50 low.
        r100 = 1'b0;
        prev = o100;
        last_edge = 0;
        rises = 0;
        falls = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk); @(negedge clk);
            if (o100 != prev) begin
                if (o100) begin
                    rises++;
                    check($sformatf("n100_rise_edge[%0d]", rises), k, 100 * rises - 50);
                end else begin
                    falls++;
                    check($sformatf("n100_high_len[%0d]", falls), k - last_edge, 50);
                end
                last_edge = k;
                prev = o100;
            end
        end
        check("n100_rises", rises, 10);
        check("n100_falls", falls, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
